// File: rtl/nn_stream_pkg.sv
// Shared types and sizing helpers for the neuron datapath streaming blocks.
package nn_stream_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } reader_state_t;

   // Words in flight plus one spare slot so a stalled consumer never forces a drop.
   function automatic int qdepth(input int read_latency);
      return read_latency + 1;
   endfunction

endpackage

// File: rtl/fifo_burst_reader_skid_queue.sv
// Small register FIFO absorbing words that arrive while the consumer stalls.
module skid_queue #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 2,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] head_o,
   output logic [CW-1:0]    count_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;

   function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q        <= bump(wr_ptr_q);
         end
         if (pop_i) rd_ptr_q <= bump(rd_ptr_q);
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Pops a programmed burst from a Fifo and streams it out as valid/ready with a last marker.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing pops, words may still be delivered
// DRAIN | all pops issued, delivering remaining words
// DONE  | one-cycle done pulse, back to IDLE
module fifo_burst_reader
   import nn_stream_pkg::*;
#(
   parameter int WIDTH        = 16,
   parameter int LEN_W        = 8,
   parameter int READ_LATENCY = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [LEN_W-1:0] burst_len,
   output logic             busy,
   output logic             done,
   input  logic             fifo_empty,
   output logic             fifo_read_update,
   input  logic [WIDTH-1:0] fifo_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last
);

   localparam int QDEPTH = qdepth(READ_LATENCY);
   localparam int CW     = $clog2(QDEPTH + 1);
   localparam int SW     = CW + 1;

   reader_state_t           state_q;
   logic [LEN_W-1:0]        issue_cnt_q, issue_cnt_d;
   logic [LEN_W-1:0]        deliver_cnt_q, deliver_cnt_d;
   logic                    busy_q, done_q;
   logic [READ_LATENCY-1:0] pipe_q;

   logic [CW-1:0]    q_count;
   logic [WIDTH-1:0] q_head;
   logic             q_empty, q_push, q_pop;
   logic             tail, xfer;
   logic [SW-1:0]    in_flight;

   always_comb begin
      in_flight = '0;
      for (int k = 0; k < READ_LATENCY; k++) in_flight = in_flight + SW'(pipe_q[k]);
   end

   assign tail    = pipe_q[READ_LATENCY-1];
   assign q_empty = (q_count == '0);

   // Credit: never have more words popped-or-queued than the queue can hold.
   assign fifo_read_update = (state_q == RUN) && (issue_cnt_q != '0) && !fifo_empty
                             && ((in_flight + SW'(q_count)) < SW'(QDEPTH));

   // A word arriving into an empty queue is presented straight away so the
   // consumer sees it READ_LATENCY cycles after its pop.
   assign out_valid = !q_empty || tail;
   assign xfer      = out_valid && out_ready;
   assign q_pop     = !q_empty && out_ready;
   assign q_push    = tail && !(q_empty && out_ready);
   assign out_last  = out_valid && (deliver_cnt_q == LEN_W'(1));

   always_comb begin
      out_data = '0;
      if (!q_empty)  out_data = q_head;
      else if (tail) out_data = fifo_data;
   end

   assign issue_cnt_d   = issue_cnt_q - LEN_W'(fifo_read_update && (issue_cnt_q != '0));
   assign deliver_cnt_d = deliver_cnt_q - LEN_W'(xfer && (deliver_cnt_q != '0));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         issue_cnt_q   <= '0;
         deliver_cnt_q <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         pipe_q        <= '0;
      end else begin
         issue_cnt_q   <= issue_cnt_d;
         deliver_cnt_q <= deliver_cnt_d;
         done_q        <= 1'b0;
         pipe_q[0]     <= fifo_read_update;
         for (int k = 1; k < READ_LATENCY; k++) pipe_q[k] <= pipe_q[k-1];
         case (state_q)
            IDLE: begin
               if (start) begin
                  if (burst_len != '0) begin
                     state_q       <= RUN;
                     issue_cnt_q   <= burst_len;
                     deliver_cnt_q <= burst_len;
                     busy_q        <= 1'b1;
                  end else begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (issue_cnt_d == '0) state_q <= DRAIN;
            end
            DRAIN: begin
               if (deliver_cnt_d == '0) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
               end
            end
            DONE: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;

   skid_queue #(
      .WIDTH (WIDTH),
      .DEPTH (QDEPTH)
   ) u_skid_queue (
      .clk     (clk),
      .reset   (reset),
      .push_i  (q_push),
      .pop_i   (q_pop),
      .data_i  (fifo_data),
      .head_o  (q_head),
      .count_o (q_count)
   );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: two builds (latency 1 and 2) each paired with a small Fifo model.
module tb_fifo_burst_reader;

   localparam int WIDTH = 16;
   localparam int LEN_W = 8;

   logic clk = 1'b0;
   logic reset;

   logic             start      [2];
   logic [LEN_W-1:0] burst_len  [2];
   logic             busy       [2];
   logic             done       [2];
   logic             fifo_empty [2];
   logic             rd         [2];
   logic [WIDTH-1:0] fifo_data  [2];
   logic             out_valid  [2];
   logic             out_ready  [2];
   logic [WIDTH-1:0] out_data   [2];
   logic             out_last   [2];

   logic [WIDTH-1:0] mem    [2][256];
   logic [7:0]       wr_ptr [2] = '{8'd0, 8'd0};
   logic [7:0]       rd_ptr [2] = '{8'd0, 8'd0};
   logic [WIDTH-1:0] d1     [2] = '{16'd0, 16'd0};
   logic [WIDTH-1:0] d2     [2] = '{16'd0, 16'd0};

   int n_checks = 0;
   int n_fail   = 0;

   logic [WIDTH-1:0] sb_q [$];
   int               cur_len;
   int               xfer_cnt  [2] = '{0, 0};
   int               outst     [2] = '{0, 0};
   int               done_cnt  [2] = '{0, 0};
   logic             prev_hold [2] = '{1'b0, 1'b0};
   logic [WIDTH-1:0] prev_data [2];

   always #5 clk = ~clk;

   fifo_burst_reader #(.WIDTH(WIDTH), .LEN_W(LEN_W), .READ_LATENCY(1)) u_dut_l1 (
      .clk(clk), .reset(reset), .start(start[0]), .burst_len(burst_len[0]),
      .busy(busy[0]), .done(done[0]), .fifo_empty(fifo_empty[0]),
      .fifo_read_update(rd[0]), .fifo_data(fifo_data[0]), .out_valid(out_valid[0]),
      .out_ready(out_ready[0]), .out_data(out_data[0]), .out_last(out_last[0])
   );

   fifo_burst_reader #(.WIDTH(WIDTH), .LEN_W(LEN_W), .READ_LATENCY(2)) u_dut_l2 (
      .clk(clk), .reset(reset), .start(start[1]), .burst_len(burst_len[1]),
      .busy(busy[1]), .done(done[1]), .fifo_empty(fifo_empty[1]),
      .fifo_read_update(rd[1]), .fifo_data(fifo_data[1]), .out_valid(out_valid[1]),
      .out_ready(out_ready[1]), .out_data(out_data[1]), .out_last(out_last[1])
   );

   // Fifo model: registered read, a second output stage for the latency-2 build.
   for (genvar g = 0; g < 2; g++) begin : g_fifo
      assign fifo_empty[g] = (wr_ptr[g] == rd_ptr[g]);
      assign fifo_data[g]  = (g == 0) ? d1[g] : d2[g];
      always @(posedge clk) begin
         if (rd[g]) begin
            d1[g]     <= mem[g][rd_ptr[g]];
            rd_ptr[g] <= rd_ptr[g] + 8'd1;
         end
         d2[g] <= d1[g];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fifo_write(input int i, input logic [WIDTH-1:0] d);
      mem[i][wr_ptr[i]] = d;
      wr_ptr[i] = wr_ptr[i] + 8'd1;
      sb_q.push_back(d);
   endtask

   task automatic start_burst(input int i, input int n);
      cur_len     = n;
      xfer_cnt[i] = 0;
      done_cnt[i] = 0;
      start[i]     = 1'b1;
      burst_len[i] = LEN_W'(n);
      tick();
      start[i]     = 1'b0;
      burst_len[i] = '0;
   endtask

   task automatic run_burst(input int i, input int budget, input bit toggle,
                            output int first_rd, output int last_rd, output int first_v);
      first_rd = -1;
      last_rd  = -1;
      first_v  = -1;
      for (int c = 0; c < budget && done_cnt[i] == 0; c++) begin
         if (rd[i]) begin
            if (first_rd < 0) first_rd = c;
            last_rd = c;
         end
         if (out_valid[i] && first_v < 0) first_v = c;
         tick();
         if (toggle) out_ready[i] = ~out_ready[i];
      end
      check("done_seen", 32'(done_cnt[i]), 32'd1);
   endtask

   task automatic end_checks(input int i);
      repeat (3) tick();
      check("done_once",  32'(done_cnt[i]), 32'd1);
      check("busy_after", 32'(busy[i]), 32'd0);
      check("word_count", 32'(xfer_cnt[i]), 32'(cur_len));
   endtask

   // Monitor: scoreboard compare, hold stability, credit bound, no pop on empty.
   initial forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         if (fifo_empty[i]) check("no_pop_on_empty", 32'(rd[i]), 32'd0);
         if (prev_hold[i]) begin
            check("hold_valid", 32'(out_valid[i]), 32'd1);
            check("hold_data", 32'(out_data[i]), 32'(prev_data[i]));
         end
         if (done[i]) done_cnt[i]++;
         if (rd[i]) begin
            outst[i]++;
            check("credit_bound", 32'(outst[i] <= i + 2), 32'd1);
         end
         if (out_valid[i]) check("last_flag", 32'(out_last[i]), 32'(xfer_cnt[i] + 1 == cur_len));
         if (out_valid[i] && out_ready[i]) begin
            if (sb_q.size() != 0) check("data", 32'(out_data[i]), 32'(sb_q.pop_front()));
            else check("scoreboard_empty", 32'(sb_q.size()), 32'd1);
            xfer_cnt[i]++;
            outst[i]--;
         end
         prev_hold[i] = out_valid[i] && !out_ready[i];
         prev_data[i] = out_data[i];
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int fr, lr, fv, k, busy_seen, rd_seen;
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         start[i] = 1'b0; burst_len[i] = '0; out_ready[i] = 1'b1;
      end
      repeat (3) tick();
      for (int i = 0; i < 2; i++) begin
         check("rst_busy",  32'(busy[i]), 32'd0);
         check("rst_done",  32'(done[i]), 32'd0);
         check("rst_pop",   32'(rd[i]), 32'd0);
         check("rst_valid", 32'(out_valid[i]), 32'd0);
         check("rst_last",  32'(out_last[i]), 32'd0);
         check("rst_data",  32'(out_data[i]), 32'd0);
      end
      reset = 1'b0;
      tick();

      // 1: full-throughput burst of 4
      for (int w = 1; w <= 4; w++) fifo_write(0, WIDTH'(w));
      start_burst(0, 4);
      run_burst(0, 50, 1'b0, fr, lr, fv);
      check("t1_latency", 32'(fv - fr), 32'd1);
      check("t1_pops_consecutive", 32'(lr - fr), 32'd3);
      end_checks(0);

      // 2: consumer stalls 5 cycles after first valid
      for (int w = 1; w <= 4; w++) fifo_write(0, WIDTH'(16'h0010 + w));
      out_ready[0] = 1'b0;
      start_burst(0, 4);
      k = 0;
      while (!out_valid[0] && k < 20) begin tick(); k++; end
      check("t2_valid_seen", 32'(out_valid[0]), 32'd1);
      repeat (5) tick();
      check("t2_none_taken", 32'(xfer_cnt[0]), 32'd0);
      out_ready[0] = 1'b1;
      run_burst(0, 50, 1'b0, fr, lr, fv);
      end_checks(0);

      // 3: Fifo runs dry mid-burst
      fifo_write(0, 16'h0101);
      fifo_write(0, 16'h0102);
      start_burst(0, 5);
      repeat (10) tick();
      check("t3_stall_busy", 32'(busy[0]), 32'd1);
      check("t3_stall_partial", 32'(xfer_cnt[0]), 32'd2);
      for (int w = 3; w <= 5; w++) begin
         fifo_write(0, WIDTH'(16'h0100 + w));
         tick();
      end
      run_burst(0, 50, 1'b0, fr, lr, fv);
      end_checks(0);

      // 4: zero-length burst
      start_burst(0, 0);
      busy_seen = 0;
      rd_seen   = 0;
      for (int c = 0; c < 5; c++) begin
         busy_seen += int'(busy[0]);
         rd_seen   += int'(rd[0]);
         tick();
      end
      check("t4_done", 32'(done_cnt[0]), 32'd1);
      check("t4_busy_never", 32'(busy_seen), 32'd0);
      check("t4_no_pop", 32'(rd_seen), 32'd0);

      // 5: reset mid-burst, then resume with the next unread word
      for (int w = 1; w <= 6; w++) fifo_write(0, WIDTH'(16'h0200 + w));
      start_burst(0, 6);
      k = 0;
      while (xfer_cnt[0] < 2 && k < 50) begin tick(); k++; end
      check("t5_two_delivered", 32'(xfer_cnt[0]), 32'd2);
      reset = 1'b1;
      #1;
      check("t5_busy",  32'(busy[0]), 32'd0);
      check("t5_done",  32'(done[0]), 32'd0);
      check("t5_pop",   32'(rd[0]), 32'd0);
      check("t5_valid", 32'(out_valid[0]), 32'd0);
      check("t5_last",  32'(out_last[0]), 32'd0);
      check("t5_data",  32'(out_data[0]), 32'd0);
      // Words already popped from the Fifo but never delivered are gone.
      while (outst[0] > 0 && sb_q.size() != 0) begin
         void'(sb_q.pop_front());
         outst[0]--;
      end
      outst[0] = 0;
      prev_hold[0] = 1'b0;
      prev_hold[1] = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      tick();
      start_burst(0, 1);
      run_burst(0, 50, 1'b0, fr, lr, fv);
      end_checks(0);

      // 6: latency-2 build, consumer ready toggling
      sb_q.delete();
      for (int w = 1; w <= 8; w++) fifo_write(1, WIDTH'(16'h0300 + w));
      start_burst(1, 8);
      run_burst(1, 100, 1'b1, fr, lr, fv);
      check("t6_latency", 32'(fv - fr), 32'd2);
      out_ready[1] = 1'b1;
      end_checks(1);
      check("t6_all_consumed", 32'(sb_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
